// File: rtl/icon_update_ctrl.sv
// Frame-synchronous icon position/orientation update controller. Two requesters feed a
// shadow register through a starvation-guarded fixed-priority arbiter, and the shadow goes live at vblank entry.
module icon_update_ctrl #(
    parameter int V_ACTIVE     = 768,
    parameter int STARVE_LIMIT = 4,
    parameter int LOC_X_INIT   = 64,
    parameter int LOC_Y_INIT   = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] pixel_row,
    input  logic [11:0] pixel_column,
    input  logic        req0_valid,
    input  logic [7:0]  req0_locX,
    input  logic [7:0]  req0_locY,
    input  logic [2:0]  req0_orient,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_locX,
    input  logic [7:0]  req1_locY,
    input  logic [2:0]  req1_orient,
    output logic        req1_ready,
    output logic [7:0]  locXReg,
    output logic [7:0]  locYReg,
    output logic [2:0]  orient,
    output logic        commit,
    output logic        pending,
    output logic [7:0]  frame_cnt
);

    // Handshake: a transfer happens when reqN_valid and reqN_ready are both high in the same cycle.
    // Readies are combinational, and at most one is high. Both are low during reset and on the frame_tick cycle.
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    localparam logic [11:0] V_ROW     = 12'(V_ACTIVE);
    localparam logic [3:0]  STARVE_LV = 4'(STARVE_LIMIT);

    state_t      state, state_next;
    logic        vblank, vblank_q, frame_tick;
    logic        force1, xfer0, xfer1;
    logic [3:0]  starve_cnt;
    logic [18:0] shadow, shadow_next;
    logic        unused_col;

    assign unused_col = ^pixel_column;
    assign vblank     = (pixel_row >= V_ROW);
    assign frame_tick = vblank & ~vblank_q;
    assign force1     = (starve_cnt >= STARVE_LV);
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;
    assign pending    = (state == PEND);

    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        state_next  = state;
        shadow_next = shadow;
        // The commit cycle owns the shadow, so no grant is issued on frame_tick.
        if (reset_n && !frame_tick) begin
            if (force1 && req1_valid)
                req1_ready = 1'b1;
            else if (req0_valid)
                req0_ready = 1'b1;
            else if (req1_valid)
                req1_ready = 1'b1;
        end
        if (xfer0) begin
            shadow_next = {req0_locX, req0_locY, req0_orient};
            state_next  = PEND;
        end else if (xfer1) begin
            shadow_next = {req1_locX, req1_locY, req1_orient};
            state_next  = PEND;
        end else if (frame_tick && state == PEND) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            vblank_q   <= 1'b1;
            starve_cnt <= 4'd0;
            shadow     <= 19'd0;
            locXReg    <= 8'(LOC_X_INIT);
            locYReg    <= 8'(LOC_Y_INIT);
            orient     <= 3'd0;
            commit     <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            state    <= state_next;
            shadow   <= shadow_next;
            vblank_q <= vblank;
            commit   <= 1'b0;
            // Counts only the req0 wins that happened while req1 was actually waiting.
            if (xfer1 || !req1_valid)
                starve_cnt <= 4'd0;
            else if (xfer0 && starve_cnt != 4'd15)
                starve_cnt <= starve_cnt + 4'd1;
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (state == PEND) begin
                    {locXReg, locYReg, orient} <= shadow;
                    commit <= 1'b1;
                end
            end
        end
    end

endmodule
